cool_heat_controller: RTL

Thermostat controller for the cool/heat subsystem. It takes an 8-bit temperature sample and runs a hysteresis state machine that selects IDLE, HEAT or COOL. A minimum-dwell lockout prevents actuator chatter. It drives the heater/cooler enables and a glitch-free fan PWM, which is timed by an internal 8-bit free-running counter.

---
 rtl/cool_heat_controller_pkg.sv | 38 +++
 rtl/cool_heat_controller_if.sv | 24 ++
 rtl/cool_heat_controller_pwm_timebase_8bit.sv | 41 ++++
 rtl/cool_heat_controller.sv | 91 +++++++++
 4 files changed

// File: rtl/cool_heat_controller_pkg.sv
// Shared types and constants for the cool/heat thermostat controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cool_heat_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2
    } state_e;

    // Default thresholds; HEAT_ON must not exceed COOL_ON so IDLE exits never collide.
    localparam logic [7:0] HEAT_ON_DEF   = 8'd15;
    localparam logic [7:0] HEAT_OFF_DEF  = 8'd20;
    localparam logic [7:0] COOL_ON_DEF   = 8'd35;
    localparam logic [7:0] COOL_OFF_DEF  = 8'd25;
    localparam logic [7:0] FAN_MID_DEF   = 8'd38;
    localparam logic [7:0] FAN_HIGH_DEF  = 8'd42;
    localparam logic [7:0] MIN_DWELL_DEF = 8'd16;

    localparam logic [7:0] DUTY_S0 = 8'd0;
    localparam logic [7:0] DUTY_S1 = 8'd64;
    localparam logic [7:0] DUTY_S2 = 8'd128;
    localparam logic [7:0] DUTY_S3 = 8'd192;

    // Fan level to PWM high-time out of a 256-cycle period.
    function automatic logic [7:0] duty_for_speed(input logic [1:0] speed);
        logic [7:0] duty;
        case (speed)
            2'd0:    duty = DUTY_S0;
            2'd1:    duty = DUTY_S1;
            2'd2:    duty = DUTY_S2;
            default: duty = DUTY_S3;
        endcase
        return duty;
    endfunction

endpackage

// File: rtl/cool_heat_controller_if.sv
// Sensor/actuator bundle between the thermostat controller and its environment.
// Latency: n/a (wiring only).
// Backpressure: none; temp is sampled every clk, outputs are always valid.
interface cool_heat_controller_if;
    logic       en;
    logic [7:0] temp;
    logic       heater_on;
    logic       cooler_on;
    logic [1:0] fan_speed;
    logic       fan_pwm;
    logic [1:0] state;
    logic       dwell_busy;
    logic [7:0] pwm_cnt;    // PWM timebase position, exported for observation

    modport master (
        output en, temp,
        input  heater_on, cooler_on, fan_speed, fan_pwm, state, dwell_busy, pwm_cnt
    );

    modport slave (
        input  en, temp,
        output heater_on, cooler_on, fan_speed, fan_pwm, state, dwell_busy, pwm_cnt
    );
endinterface

// File: rtl/cool_heat_controller_pwm_timebase_8bit.sv
// Free-running 8-bit PWM timebase with a duty latch that only updates on wrap.
// Latency: fan_speed change reaches fan_pwm at the next 255->0 wrap, +1 clk register.
// Backpressure: none; counter runs every clk regardless of controller state.
module pwm_timebase_8bit
    import cool_heat_controller_pkg::*;
(
    input  logic       clk,
    input  logic       arst,
    input  logic [1:0] fan_speed,
    output logic [7:0] pwm_cnt,
    output logic       fan_pwm
);

    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0] duty_active_q, duty_active_d;
    logic       fan_pwm_q, fan_pwm_d;

    // Next count; duty only reloads on the wrap edge so a period is never cut short or stretched.
    always_comb begin
        pwm_cnt_d     = pwm_cnt_q + 8'd1;
        duty_active_d = (pwm_cnt_q == 8'hFF) ? duty_for_speed(fan_speed) : duty_active_q;
        fan_pwm_d     = (pwm_cnt_d < duty_active_d);
    end

    // Timebase, duty latch and registered PWM output.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pwm_cnt_q     <= 8'd0;
            duty_active_q <= 8'd0;
            fan_pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            duty_active_q <= duty_active_d;
            fan_pwm_q     <= fan_pwm_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;
    assign fan_pwm = fan_pwm_q;

endmodule

// File: rtl/cool_heat_controller.sv
// Hysteresis thermostat FSM (IDLE/HEAT/COOL) with dwell lockout, fan level and fan PWM.
// Latency: temp/en to heater/cooler/fan_speed/state = 1 clk.
// Backpressure: none; a new temp sample is consumed every clk.
module cool_heat_controller
    import cool_heat_controller_pkg::*;
#(
    parameter logic [7:0] HEAT_ON   = HEAT_ON_DEF,
    parameter logic [7:0] HEAT_OFF  = HEAT_OFF_DEF,
    parameter logic [7:0] COOL_ON   = COOL_ON_DEF,
    parameter logic [7:0] COOL_OFF  = COOL_OFF_DEF,
    parameter logic [7:0] FAN_MID   = FAN_MID_DEF,
    parameter logic [7:0] FAN_HIGH  = FAN_HIGH_DEF,
    parameter logic [7:0] MIN_DWELL = MIN_DWELL_DEF
) (
    input  logic                   clk,
    input  logic                   arst,
    cool_heat_controller_if.slave  bus
);

    state_e     state_q, state_d;
    logic [7:0] dwell_q, dwell_d;
    logic       heater_on_q, heater_on_d;
    logic       cooler_on_q, cooler_on_d;
    logic [1:0] fan_speed_q, fan_speed_d;

    // Next state, dwell and outputs; outputs are decoded from state_d so they move with state.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (dwell_q == 8'd0) begin
                    if (bus.temp < HEAT_ON)      state_d = ST_HEAT;
                    else if (bus.temp > COOL_ON) state_d = ST_COOL;
                end
                ST_HEAT: if (dwell_q == 8'd0 && bus.temp >= HEAT_OFF) state_d = ST_IDLE;
                ST_COOL: if (dwell_q == 8'd0 && bus.temp <= COOL_OFF) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d != state_q)  dwell_d = MIN_DWELL;
        else if (dwell_q != 8'd0) dwell_d = dwell_q - 8'd1;
        else                      dwell_d = 8'd0;

        heater_on_d = (state_d == ST_HEAT);
        cooler_on_d = (state_d == ST_COOL);
        case (state_d)
            ST_HEAT: fan_speed_d = 2'd1;
            ST_COOL: begin
                if (bus.temp >= FAN_HIGH)     fan_speed_d = 2'd3;
                else if (bus.temp >= FAN_MID) fan_speed_d = 2'd2;
                else                          fan_speed_d = 2'd1;
            end
            default: fan_speed_d = 2'd0;
        endcase
    end

    // FSM state, dwell lockout and registered actuator outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            dwell_q     <= 8'd0;
            heater_on_q <= 1'b0;
            cooler_on_q <= 1'b0;
            fan_speed_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            heater_on_q <= heater_on_d;
            cooler_on_q <= cooler_on_d;
            fan_speed_q <= fan_speed_d;
        end
    end

    pwm_timebase_8bit u_pwm (
        .clk       (clk),
        .arst      (arst),
        .fan_speed (fan_speed_q),
        .pwm_cnt   (bus.pwm_cnt),
        .fan_pwm   (bus.fan_pwm)
    );

    assign bus.state      = state_q;
    assign bus.heater_on  = heater_on_q;
    assign bus.cooler_on  = cooler_on_q;
    assign bus.fan_speed  = fan_speed_q;
    assign bus.dwell_busy = (dwell_q != 8'd0);

endmodule
